// File: rtl/dmem_load_unit_pkg.sv
// Shared definitions for the data-memory load path: format codes, FSM states
// and the legality/alignment rule applied when a request is accepted.
package dmem_load_unit_pkg;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_HU = 3'b010;
  localparam logic [2:0] LD_B  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } ld_state_t;

  // True when the format is defined and the byte offset suits its width.
  function automatic logic ld_legal(input logic [2:0] fmt, input logic [1:0] lo);
    logic ok;
    case (fmt)
      LD_W:         ok = (lo == 2'b00);
      LD_H, LD_HU:  ok = (lo[0] == 1'b0);
      LD_B, LD_BU:  ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_load_unit_extract.sv
// Lane select and sign/zero extension of a 32-bit memory word for the
// supported load formats.
module load_extract
  import dmem_load_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  format,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'b00:   byte_sel = word[7:0];
      2'b01:   byte_sel = word[15:8];
      2'b10:   byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  always_comb begin
    data = '0;
    case (format)
      LD_W:    data = word;
      LD_H:    data = {{16{half[15]}}, half};
      LD_HU:   data = {16'h0000, half};
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'h000000, byte_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_load_unit.sv
// Load controller: accepts a load, performs one memory read cycle and returns
// the extended result, or reports a misaligned/illegal request without access.
module dmem_load_unit #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [2:0]        ld_format,
  input  logic [31:0]       ld_addr,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [31:0]       ld_data,
  output logic              ld_exc,
  output logic              dm_r,
  output logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_rdata
);
  import dmem_load_unit_pkg::*;

  ld_state_t         state;
  logic [2:0]        fmt_q;
  logic [1:0]        lo_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       ext_data;
  logic              unused_addr_hi;

  // Address bits above the memory's reach are deliberately ignored (wrap).
  assign unused_addr_hi = ^ld_addr[31:ADDR_W+2];

  load_extract u_extract (
    .word    (dm_rdata),
    .addr_lo (lo_q),
    .format  (fmt_q),
    .data    (ext_data)
  );

  assign ld_ready = (state != ST_ACCESS);
  assign ld_done  = (state == ST_DONE);
  assign dm_r     = (state == ST_ACCESS);
  assign dm_addr  = (state == ST_ACCESS) ? waddr_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      fmt_q   <= '0;
      lo_q    <= '0;
      waddr_q <= '0;
      ld_data <= '0;
      ld_exc  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (ld_req) begin
            fmt_q   <= ld_format;
            lo_q    <= ld_addr[1:0];
            waddr_q <= ld_addr[ADDR_W+1:2];
            if (ld_legal(ld_format, ld_addr[1:0])) begin
              state <= ST_ACCESS;
            end else begin
              state   <= ST_DONE;
              ld_data <= '0;
              ld_exc  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          ld_data <= ext_data;
          ld_exc  <= 1'b0;
          state   <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
